fetch_controller: RTL

Instruction-fetch sequencer between the instruction-memory port and the 16-bit realign buffer. Issues word-aligned fetch requests, tracks outstanding responses, queues returned words in a 2-entry response FIFO, and writes them into the realign buffer under its full back-pressure. On a redirect it clears the realign buffer with the correct halfword offset and discards stale in-flight responses.

---
 rtl/fetch_controller_pkg.sv | 26 ++
 rtl/fetch_controller_fifo.sv | 66 ++++++
 rtl/fetch_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared widths, FSM encoding and payload types for the instruction-fetch sequencer.
package fetch_controller_pkg;

    localparam int unsigned RISCV_ADDR_WIDTH = 32;
    localparam int unsigned RISCV_WORD_WIDTH = 32;
    localparam int unsigned CNT_WIDTH        = 2;
    localparam logic [RISCV_ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [RISCV_WORD_WIDTH-1:0] instr;
        logic [RISCV_ADDR_WIDTH-1:0] addr;
    } resp_t;

    localparam int unsigned RESP_WIDTH = $bits(resp_t);

    function automatic logic [RISCV_ADDR_WIDTH-1:0] word_align(input logic [RISCV_ADDR_WIDTH-1:0] a);
        return {a[RISCV_ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_controller_fifo.sv
// Two-entry synchronous FIFO with flush; head is always visible on data_o.
module fetch_controller_fifo
    import fetch_controller_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     data_i,
    input  logic                 pop_i,
    output logic [WIDTH-1:0]     data_o,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [WIDTH-1:0]     mem_q [2];
    logic [WIDTH-1:0]     mem_d [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 do_push;
    logic                 do_pop;

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i & (count_q != '0);
        do_push  = push_i & ((count_q != CNT_WIDTH'(2)) | do_pop);
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_WIDTH'(do_push) - CNT_WIDTH'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: issues word fetches, tracks responses, feeds the realign buffer,
// and flushes/discards stale traffic on redirect.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [RISCV_ADDR_WIDTH-1:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int unsigned                 MAX_OUTSTANDING = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        redirect_i,
    input  logic [RISCV_ADDR_WIDTH-1:0] redirect_addr_i,
    input  logic                        halt_i,
    output logic                        imem_req_o,
    output logic [RISCV_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                        imem_gnt_i,
    input  logic                        imem_rvalid_i,
    input  logic [RISCV_WORD_WIDTH-1:0] imem_rdata_i,
    output logic                        buf_clear_o,
    output logic                        buf_offset_o,
    output logic                        buf_write_en_o,
    output logic [RISCV_WORD_WIDTH-1:0] buf_instr_o,
    output logic [RISCV_ADDR_WIDTH-1:0] buf_addr_o,
    input  logic                        buf_full_i
);

    fetch_state_e                state_q, state_d;
    logic [RISCV_ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [CNT_WIDTH-1:0]        outstanding_q, outstanding_d;
    logic [CNT_WIDTH-1:0]        discard_cnt_q, discard_cnt_d;
    logic [CNT_WIDTH-1:0]        afifo_count;
    logic [CNT_WIDTH-1:0]        rfifo_count;
    logic [RISCV_ADDR_WIDTH-1:0] rsp_addr;
    logic                        rfifo_push;
    logic [2:0]                  occupancy;
    resp_t                       rfifo_in;
    resp_t                       rfifo_head;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect overrides the current state
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = halt_i ? HALT : RUN;
            HALT:    state_d = halt_i ? HALT : RUN;
            default: state_d = BOOT;
        endcase
        if (redirect_i) begin
            state_d = halt_i ? HALT : RUN;
        end
    end

    // Output logic; the BOOT clear is gated so it cannot appear while reset is held
    always_comb begin
        imem_req_o     = 1'b0;
        buf_clear_o    = 1'b0;
        buf_offset_o   = 1'b0;
        buf_write_en_o = 1'b0;
        if (state_q == RUN && !redirect_i && occupancy < 3'(MAX_OUTSTANDING)) begin
            imem_req_o = 1'b1;
        end
        if (redirect_i) begin
            buf_clear_o  = 1'b1;
            buf_offset_o = redirect_addr_i[1];
        end else if (state_q == BOOT && rst_n) begin
            buf_clear_o  = 1'b1;
            buf_offset_o = RESET_PC[1];
        end
        if (rfifo_count != '0 && !buf_full_i && !redirect_i) begin
            buf_write_en_o = 1'b1;
        end
    end

    // Fetch address, in-flight accounting and stale-response discard
    always_comb begin
        fetch_addr_d  = fetch_addr_q;
        discard_cnt_d = discard_cnt_q;
        rfifo_push    = 1'b0;
        outstanding_d = outstanding_q + CNT_WIDTH'(imem_gnt_i) - CNT_WIDTH'(imem_rvalid_i);
        if (redirect_i) begin
            fetch_addr_d = word_align(redirect_addr_i);
        end else if (imem_gnt_i) begin
            fetch_addr_d = fetch_addr_q + RISCV_ADDR_WIDTH'(4);
        end
        if (imem_rvalid_i) begin
            if (discard_cnt_q != '0) begin
                discard_cnt_d = discard_cnt_q - CNT_WIDTH'(1);
            end else begin
                rfifo_push = ~redirect_i;
            end
        end
        // Everything still in flight after this cycle belongs to the old stream.
        if (redirect_i) begin
            discard_cnt_d = outstanding_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_addr_q  <= word_align(RESET_PC);
            outstanding_q <= '0;
            discard_cnt_q <= '0;
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            outstanding_q <= outstanding_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    assign occupancy   = 3'(outstanding_q) + 3'(rfifo_count);
    assign imem_addr_o = fetch_addr_q;
    assign rfifo_in    = '{instr: imem_rdata_i, addr: rsp_addr};
    assign buf_instr_o = rfifo_head.instr;
    assign buf_addr_o  = rfifo_head.addr;

    fetch_controller_fifo #(
        .WIDTH (RISCV_ADDR_WIDTH)
    ) u_addr_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (1'b0),
        .push_i  (imem_gnt_i),
        .data_i  (fetch_addr_q),
        .pop_i   (imem_rvalid_i),
        .data_o  (rsp_addr),
        .count_o (afifo_count)
    );

    fetch_controller_fifo #(
        .WIDTH (RESP_WIDTH)
    ) u_resp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_i),
        .push_i  (rfifo_push),
        .data_i  (rfifo_in),
        .pop_i   (buf_write_en_o),
        .data_o  (rfifo_head),
        .count_o (rfifo_count)
    );

    // Protocol sanity
    a_occupancy: assert property (@(posedge clk) disable iff (!rst_n)
        occupancy <= 3'(MAX_OUTSTANDING));
    a_rvalid_tracked: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid_i |-> (outstanding_q != '0));
    a_addr_fifo_sync: assert property (@(posedge clk) disable iff (!rst_n)
        afifo_count == outstanding_q);
    a_redirect_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        redirect_i |-> !redirect_addr_i[0]);

endmodule
